// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - register map and defaults for the button event controller
package button_event_pkg;

    localparam logic [1:0] REG_STATE   = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_CAPTURE = 2'd3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/button_event_controller_if.sv
// rtl/button_event_controller_if.sv - register slave bus for the button event controller
interface button_event_controller_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - single-bit synchronizer and debounce counter with edge pulses
module button_debouncer
    import button_event_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] count;
    logic          accept;

    // Pulses are combinational so the capture register sets on the same edge stable changes.
    assign accept     = (sync != stable) && (count == CNT_MAX);
    assign rise_pulse = accept & sync;
    assign fall_pulse = accept & ~sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= IDLE_LEVEL;
            sync   <= IDLE_LEVEL;
            stable <= IDLE_LEVEL;
            count  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                count <= '0;
            end else if (accept) begin
                stable <= sync;
                count  <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_controller.sv
// rtl/button_event_controller.sv - debounced push-button edge capture with masked interrupt
module button_event_controller
    import button_event_pkg::*;
#(
    parameter int   N_BTN           = 3,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    button_event_controller_if.slave bus,
    input  logic [N_BTN-1:0]         in_port,
    output logic                     irq
);

    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] mask;
    logic [N_BTN-1:0] edge_sel;
    logic [N_BTN-1:0] capture;
    logic [N_BTN-1:0] set_bits;
    logic [N_BTN-1:0] clr_bits;
    logic             wr;
    logic [31:0]      rd_mux;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_debouncer (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw        (in_port[i]),
            .stable     (stable[i]),
            .rise_pulse (rise[i]),
            .fall_pulse (fall[i])
        );
    end

    always_comb begin
        wr       = bus.chipselect & ~bus.write_n;
        set_bits = (edge_sel & rise) | (~edge_sel & fall);
        clr_bits = (wr && bus.address == REG_CAPTURE) ? bus.writedata[N_BTN-1:0] : '0;
        rd_mux   = '0;
        case (bus.address)
            REG_STATE:   rd_mux[N_BTN-1:0] = stable;
            REG_MASK:    rd_mux[N_BTN-1:0] = mask;
            REG_EDGE:    rd_mux[N_BTN-1:0] = edge_sel;
            REG_CAPTURE: rd_mux[N_BTN-1:0] = capture;
            default:     rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask         <= '0;
            edge_sel     <= '0;
            capture      <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == REG_MASK) begin
                mask <= bus.writedata[N_BTN-1:0];
            end
            if (wr && bus.address == REG_EDGE) begin
                edge_sel <= bus.writedata[N_BTN-1:0];
            end
            // A new event on the same edge as a clear keeps the bit set.
            capture      <= (capture & ~clr_bits) | set_bits;
            irq          <= |(capture & mask);
            bus.readdata <= bus.chipselect ? rd_mux : '0;
        end
    end

endmodule
